// File: rtl/simple_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : simple_dmem_resp
// Purpose  : Data-memory responder for the core's load/store path. Accepts one
//            word-aligned read or byte-strobed write at a time and answers on
//            a valid/ready response channel after a programmable latency.
// Ports    : clk, reset            - clock (rising edge), async active-high reset
//            req_valid/req_ready   - request handshake
//            req_we/addr/wdata/wstrb - request payload (wstrb ignored on reads)
//            rsp_valid/rsp_ready   - response handshake
//            rsp_rdata/rsp_err     - read data (0 for writes/errors), error flag
// Revision : 1.0 - initial release
// ============================================================================
module simple_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned C_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  C_LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_en_q;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic               accept;
  logic               rsp_fire;
  logic               commit;
  logic               eff_we;
  logic [31:0]        eff_addr;
  logic [31:0]        eff_wdata;
  logic [3:0]         eff_wstrb;
  logic [31:0]        offset;
  logic [31:0]        word_idx;
  logic               eff_err;
  logic [C_IDX_W-1:0] idx;

  // ready_en_q keeps req_ready low while reset is held and for the edge it is
  // released on; the responder starts accepting one clock later.
  assign req_ready = ready_en_q && (state_q == C_IDLE);
  assign rsp_valid = (state_q == C_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept   = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // With LATENCY=1 the commit lands on the accepting edge itself, before the
  // request has been latched, so the live request stands in for the copy.
  assign eff_we    = (state_q == C_IDLE) ? req_we    : we_q;
  assign eff_addr  = (state_q == C_IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == C_IDLE) ? req_wdata : wdata_q;
  assign eff_wstrb = (state_q == C_IDLE) ? req_wstrb : wstrb_q;

  assign offset   = eff_addr - BASE_ADDR;
  assign word_idx = {2'b00, offset[31:2]};
  assign eff_err  = (eff_addr[1:0] != 2'b00) || (eff_addr < BASE_ADDR) ||
                    (word_idx >= DEPTH_WORDS);
  assign idx      = word_idx[C_IDX_W-1:0];

  // The edge that moves the FSM into RESP is the single commit point.
  assign commit = ((state_q == C_IDLE) && accept && (LATENCY == 1)) ||
                  ((state_q == C_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      C_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = C_LAT_M1;
          state_d = (LATENCY == 1) ? C_RESP : C_WAIT;
        end
      end
      C_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = C_RESP;
        end
      end
      C_RESP: begin
        if (rsp_fire) begin
          state_d     = C_IDLE;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = C_IDLE;
    endcase
    if (commit) begin
      rsp_err_d   = eff_err;
      rsp_rdata_d = (!eff_we && !eff_err) ? mem[idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= C_IDLE;
      cnt_q       <= 4'd0;
      ready_en_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_en_q  <= 1'b1;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is never cleared; only strobed bytes of an error-free write change.
  always_ff @(posedge clk) begin
    if (commit && !reset && eff_we && !eff_err) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_wstrb[b]) begin
          mem[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
        end
      end
    end
  end

  // The wait counter is 4 bits wide and the base must be word-aligned.
  if ((LATENCY < 1) || (LATENCY > 15) || (BASE_ADDR[1:0] != 2'b00)) begin : g_bad_config
    always_ff @(posedge clk) begin
      assert (1'b0) else $error("simple_dmem_resp: illegal LATENCY or BASE_ADDR");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simple_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_dmem_resp
// Purpose  : Self-checking bench for simple_dmem_resp. Three instances with
//            LATENCY 2, 1 and 4 share clock and reset; a reference memory
//            model feeds a scoreboard of expected responses and accept times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_dmem_resp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wstrb [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  logic [31:0] mdl [3][256];
  exp_t        exp_q[$];
  int          acc_q[$];
  logic        prev_valid [3];
  int          cyc = 0;
  int          last_acc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    simple_dmem_resp #(
      .DEPTH_WORDS(256),
      .BASE_ADDR  (32'h0000_0000),
      .LATENCY    ((i == 0) ? 2 : (i == 1) ? 1 : 4)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[i]),
      .req_ready(req_ready[i]),
      .req_we   (req_we[i]),
      .req_addr (req_addr[i]),
      .req_wdata(req_wdata[i]),
      .req_wstrb(req_wstrb[i]),
      .rsp_valid(rsp_valid[i]),
      .rsp_ready(rsp_ready[i]),
      .rsp_rdata(rsp_rdata[i]),
      .rsp_err  (rsp_err[i])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Response monitor: latency of every rising rsp_valid (the accepting edge
  // counts as the first edge) and payload of every response handshake.
  always @(negedge clk) begin
    int   a;
    exp_t e;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (rsp_valid[k] && !prev_valid[k]) begin
          if (acc_q.size() == 0) begin
            check("spurious_rsp_valid", 32'd1, 32'd0);
          end else begin
            a = acc_q.pop_front();
            check($sformatf("latency_dut%0d", k), 32'(cyc - a + 1), 32'(lat_of(k)));
          end
        end
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rdata_dut%0d", k), rsp_rdata[k], e.rdata);
            check($sformatf("err_dut%0d", k), {31'd0, rsp_err[k]}, {31'd0, e.err});
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) prev_valid[k] = reset ? 1'b0 : rsp_valid[k];
  end

  // Drive one request, wait (bounded) for acceptance, then record the accept
  // time and the model's expected response.
  task automatic send(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb, input bit hold);
    int   t;
    exp_t e;
    logic err;
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
    t = 0;
    @(negedge clk);
    while (!req_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[k]) begin
      check("accept_timeout", {31'd0, req_ready[k]}, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    acc_q.push_back(cyc + 1);
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
    e.err = err;
    if (we) begin
      e.rdata = 32'h0;
      if (!err) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mdl[k][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end else begin
      e.rdata = err ? 32'h0 : mdl[k][addr[9:2]];
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t;
    int prev;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_wstrb[k] = 4'h0;
      rsp_ready[k] = 1'b1;
      prev_valid[k] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_req_ready", {31'd0, req_ready[k]}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata[k], 32'h0);
      check("reset_rsp_err",   {31'd0, rsp_err[k]}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("ready_after_reset", {31'd0, req_ready[k]}, 32'd1);

    // LATENCY=2: full write then read back
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    // byte strobes
    send(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    send(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    // errors: misaligned read, out-of-range write must not alias word 0
    send(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0);
    send(0, 1'b1, 32'h0, 32'h5A5A0001, 4'hF, 1'b0);
    send(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0);
    send(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    // zero-strobe write is a no-op without error
    send(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 1'b0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    drain();

    // backpressure: response held for 5 cycles
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    t = 0;
    while (!rsp_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata[0], 32'h11BB33DD);
      check("bp_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    check("bp_idle_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("bp_idle_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    rsp_ready[0] = 1'b1;
    drain();

    // LATENCY=1: back-to-back reads with req_valid held high
    send(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b0);
    send(1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, 1'b0);
    send(1, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF, 1'b0);
    drain();
    send(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    prev = last_acc;
    send(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1);
    check("b2b_spacing1", 32'(last_acc - prev), 32'd2);
    prev = last_acc;
    send(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
    check("b2b_spacing2", 32'(last_acc - prev), 32'd2);
    req_valid[1] = 1'b0;
    drain();

    // LATENCY=4: reset while a write waits discards the write
    send(2, 1'b1, 32'h30, 32'h01020304, 4'hF, 1'b0);
    drain();
    send(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0);
    mdl[2][12] = 32'h01020304;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready[2]}, 32'd0);
    check("midrst_rsp_rdata", rsp_rdata[2], 32'h0);
    check("midrst_rsp_err",   {31'd0, rsp_err[2]}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send(2, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
